// File: rtl/axis_master.sv
// AXI-Stream transmit master: backend valid/ready beats into a small FIFO
// feeding one registered output stage that drives every AXIS output.
module axis_master #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 2)
) (
    input  logic          axi_aclk,
    input  logic          axi_reset,
    input  logic [31:0]   bk_data,
    input  logic [1:0]    bk_user,
    input  logic          bk_last,
    input  logic          bk_valid,
    output logic          bk_ready,
    output logic          axis_tvalid,
    output logic [31:0]   axis_tdata,
    output logic [3:0]    axis_tstrb,
    output logic [3:0]    axis_tkeep,
    output logic          axis_tlast,
    output logic [1:0]    axis_tuser,
    input  logic          axis_tready,
    output logic [LW-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = 35;

    typedef logic [BW-1:0] beat_t;

    beat_t          mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           or_vld_q, or_vld_d;
    beat_t          or_q, or_d;
    logic [LW-1:0]  occ_q, occ_d;
    logic           wr, rd, push, pop;
    beat_t          bk_beat;

    assign bk_beat  = {bk_last, bk_user, bk_data};
    // Ready comes from the registered count only, never from axis_tready.
    assign bk_ready = ~axi_reset & (cnt_q != CW'(DEPTH));
    assign wr       = bk_valid & bk_ready;
    assign rd       = or_vld_q & axis_tready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        or_vld_d = or_vld_q;
        or_d     = or_q;
        push     = 1'b0;
        pop      = 1'b0;
        if (~or_vld_q | rd) begin
            if (cnt_q != '0) begin
                or_d     = mem_q[rd_ptr_q];
                or_vld_d = 1'b1;
                pop      = 1'b1;
                push     = wr;
            end else if (wr) begin
                or_d     = bk_beat;
                or_vld_d = 1'b1;
            end else begin
                or_vld_d = 1'b0;
            end
        end else begin
            push = wr;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        occ_d = LW'(cnt_d) + LW'(or_vld_d);
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            or_vld_q <= 1'b0;
            or_q     <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            or_vld_q <= or_vld_d;
            or_q     <= or_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bk_beat;
        end
    end

    assign axis_tvalid = or_vld_q;
    assign {axis_tlast, axis_tuser, axis_tdata} = or_q;
    assign axis_tstrb  = {4{or_vld_q}};
    assign axis_tkeep  = {4{or_vld_q}};
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_axis_master.sv
// Bench for axis_master: directed scenarios plus random traffic, all checked
// against a queue model of the beats held by the block.
module tb_axis_master;

    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   bk_data;
    logic [1:0]    bk_user;
    logic          bk_last;
    logic          bk_valid;
    logic          bk_ready;
    logic          axis_tvalid;
    logic [31:0]   axis_tdata;
    logic [3:0]    axis_tstrb;
    logic [3:0]    axis_tkeep;
    logic          axis_tlast;
    logic [1:0]    axis_tuser;
    logic          axis_tready;
    logic [LW-1:0] occupancy;

    always #5 clk = ~clk;

    axis_master #(.DEPTH(DEPTH), .LW(LW)) dut (
        .axi_aclk    (clk),
        .axi_reset   (rst),
        .bk_data     (bk_data),
        .bk_user     (bk_user),
        .bk_last     (bk_last),
        .bk_valid    (bk_valid),
        .bk_ready    (bk_ready),
        .axis_tvalid (axis_tvalid),
        .axis_tdata  (axis_tdata),
        .axis_tstrb  (axis_tstrb),
        .axis_tkeep  (axis_tkeep),
        .axis_tlast  (axis_tlast),
        .axis_tuser  (axis_tuser),
        .axis_tready (axis_tready),
        .occupancy   (occupancy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int maxocc = 0;
    int sent;
    int wcyc;
    logic acc;
    logic popd;
    logic [34:0] mq[$];
    logic [34:0] got[$];
    int popcyc[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge against the model, then advance.
    task automatic tick();
        logic ev;
        logic rdy;
        logic [34:0] h;
        h = '0;
        @(negedge clk);
        ev  = (mq.size() != 0);
        rdy = !rst && (mq.size() != DEPTH + 1);
        if (ev) h = mq[0];
        chk("tvalid", axis_tvalid, ev);
        chk("bk_ready", bk_ready, rdy);
        chk("occupancy", occupancy, mq.size());
        chk("tstrb", axis_tstrb, {4{ev}});
        chk("tkeep", axis_tkeep, {4{ev}});
        if (ev) chk("beat", {axis_tlast, axis_tuser, axis_tdata}, h);
        if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
        acc  = bk_valid && rdy;
        popd = ev && axis_tready;
        if (popd) begin
            got.push_back(h);
            popcyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
        end else begin
            if (popd) void'(mq.pop_front());
            if (acc) mq.push_back({bk_last, bk_user, bk_data});
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bk_valid = 1'b1;
        bk_data = 32'hDEAD_BEEF;
        bk_user = 2'b11;
        bk_last = 1'b1;
        axis_tready = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();

        // Reset held with a beat offered
        repeat (3) tick();
        chk("rst_bk_ready", bk_ready, 1'b0);
        chk("rst_tdata", axis_tdata, 32'h0);
        rst = 1'b0;
        bk_valid = 1'b0;
        axis_tready = 1'b1;
        repeat (3) tick();
        chk("rst_no_beat", got.size(), 0);

        // Single beat latency
        bk_data = 32'h0000_0001;
        bk_user = 2'b10;
        bk_last = 1'b1;
        bk_valid = 1'b1;
        wcyc = cyc;
        tick();
        bk_valid = 1'b0;
        tick();
        tick();
        chk("single_cnt", got.size(), 1);
        if (got.size() == 1) begin
            chk("single_beat", got[0], {1'b1, 2'b10, 32'h1});
            chk("single_lat", popcyc[0], wcyc + 1);
        end
        chk("single_occ", occupancy, 0);
        got.delete();
        popcyc.delete();

        // Fill under back-pressure
        axis_tready = 1'b0;
        bk_valid = 1'b1;
        bk_user = 2'b00;
        bk_last = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bk_data = 32'h10 + i;
            tick();
        end
        chk("fill_occ", occupancy, 5);
        chk("fill_ready", bk_ready, 1'b0);
        repeat (10) begin
            tick();
            chk("hold_tdata", axis_tdata, 32'h10);
        end

        // Drain, with the held 0x15 beat accepted once room appears
        axis_tready = 1'b1;
        tick();
        chk("ready_after_pop", bk_ready, 1'b1);
        tick();
        chk("drain_acc", acc, 1'b1);
        bk_valid = 1'b0;
        repeat (8) tick();
        chk("drain_cnt", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            chk("drain_order", got[i][31:0], 32'h10 + i);
        if (got.size() >= 5)
            chk("drain_b2b", popcyc[4] - popcyc[0], 4);
        got.delete();
        popcyc.delete();

        // Streaming at full rate
        maxocc = 0;
        sent = 0;
        bk_valid = 1'b1;
        axis_tready = 1'b1;
        for (int k = 0; k < 200 && sent < 64; k++) begin
            bk_data = sent;
            bk_last = (sent % 8 == 7);
            tick();
            if (acc) sent++;
        end
        bk_valid = 1'b0;
        repeat (4) tick();
        chk("stream_cnt", got.size(), 64);
        if (got.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk("stream_data", got[i][31:0], i);
                chk("stream_last", got[i][34], (i % 8 == 7));
            end
            chk("stream_bubbles", popcyc[63] - popcyc[0], 63);
        end
        chk("stream_maxocc", maxocc <= 1, 1'b1);
        got.delete();
        popcyc.delete();

        // Random traffic with a reset in the middle
        for (int c = 0; c < 500; c++) begin
            if (c == 250) rst = 1'b1;
            if (c == 252) rst = 1'b0;
            bk_valid = 1'($urandom);
            bk_data = $urandom;
            bk_user = 2'($urandom);
            bk_last = 1'($urandom);
            axis_tready = 1'($urandom);
            tick();
            if (c == 251) begin
                chk("midrst_occ", occupancy, 0);
                chk("midrst_tvalid", axis_tvalid, 1'b0);
            end
        end
        bk_valid = 1'b0;
        axis_tready = 1'b1;
        repeat (8) tick();
        chk("final_empty", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
